// File: rtl/memcopy_ctrl.sv
// Memcopy sequencer: freezes the core and copies N words through the dmem port, then writes N to rd.
// Latency: 2N+2 cycles per instruction (1 detect + N read/write pairs + unstalled DONE).
// Backpressure: none; stall is driven combinationally on decode and held until DONE.
module memcopy_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        mc_active,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_we,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata
);
    localparam logic [6:0] OPCODE = 7'b0001011;
    localparam logic [2:0] FUNCT3 = 3'b000;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] src, dst, buffer;
    logic [6:0]  cnt, idx;
    logic [4:0]  rd;
    logic        hit, last_word;
    logic [31:0] word_off;

    assign hit       = (instruction[6:0] == OPCODE) && (instruction[14:12] == FUNCT3);
    assign last_word = ({1'b0, idx} + 8'd1) >= {1'b0, cnt};
    assign word_off  = {23'b0, idx, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = (instruction[31:25] != 7'd0) ? READ : DONE;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bases are latched at decode so an rd that aliases rs1/rs2 cannot disturb the copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src    <= 32'd0;
            dst    <= 32'd0;
            cnt    <= 7'd0;
            rd     <= 5'd0;
            idx    <= 7'd0;
            buffer <= 32'd0;
        end else begin
            case (state)
                IDLE: if (hit) begin
                    src <= {rs1_data[31:2], 2'b00};
                    dst <= {rs2_data[31:2], 2'b00};
                    cnt <= instruction[31:25];
                    rd  <= instruction[11:7];
                    idx <= 7'd0;
                end
                READ:    buffer <= dmem_rdata;
                WRITE:   idx <= idx + 7'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        stall      = 1'b0;
        mc_active  = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        dmem_we    = 1'b0;
        rd_we      = 1'b0;
        rd_addr    = 5'd0;
        rd_wdata   = 32'd0;
        case (state)
            IDLE: stall = hit;
            READ: begin
                stall     = 1'b1;
                mc_active = 1'b1;
                dmem_addr = src + word_off;
            end
            WRITE: begin
                stall      = 1'b1;
                mc_active  = 1'b1;
                dmem_we    = 1'b1;
                dmem_addr  = dst + word_off;
                dmem_wdata = buffer;
            end
            DONE: begin
                rd_we    = (rd != 5'd0);
                rd_addr  = rd;
                rd_wdata = {25'b0, cnt};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_memcopy_ctrl.sv
// Directed + randomized bench for memcopy_ctrl against a word-copy reference model.
module tb_memcopy_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [31:0] dmem_rdata;
    logic        stall, mc_active, dmem_we, rd_we;
    logic [31:0] dmem_addr, dmem_wdata, rd_wdata;
    logic [4:0]  rd_addr;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem  [256];
    logic [31:0] refm [256];

    memcopy_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .dmem_rdata(dmem_rdata),
        .stall(stall), .mc_active(mc_active), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .rd_we(rd_we),
        .rd_addr(rd_addr), .rd_wdata(rd_wdata)
    );

    always #5 clk = ~clk;

    always_comb dmem_rdata = mem[dmem_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int n, input int rs2, input int rs1,
                                       input int f3, input int rd);
        logic [31:0] w;
        w = {n[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0001011};
        return w;
    endfunction

    task automatic chk_mem(input string tag);
        for (int i = 0; i < 256; i++) chk(tag, mem[i], refm[i]);
    endtask

    // Executes one instruction as the core would: present it until stall drops.
    task automatic run_mc(input logic [31:0] instr, input logic [31:0] r1,
                          input logic [31:0] r2, input int abort_at);
        logic        hit;
        int          n, total, cyc, k;
        logic [4:0]  rd;
        logic [31:0] src, dst, held, exp_addr;
        logic        exp_stall, exp_act, exp_we, finished, pend;
        logic [31:0] pa, pd;
        hit   = (instr[6:0] == 7'b0001011) && (instr[14:12] == 3'b000);
        n     = int'(instr[31:25]);
        rd    = instr[11:7];
        src   = {r1[31:2], 2'b00};
        dst   = {r2[31:2], 2'b00};
        total = hit ? 2 * n + 2 : 1;
        held  = 32'd0;
        for (int i = 0; i < 256; i++) refm[i] = mem[i];
        finished = 1'b0;
        cyc = 0;
        while (!finished) begin
            @(negedge clk);
            instruction = instr;
            rs1_data    = r1;
            rs2_data    = r2;
            #1;
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                instruction = 32'd0;
                #1;
                chk("rst_stall", stall, 0);
                chk("rst_active", mc_active, 0);
                chk("rst_we", dmem_we, 0);
                chk("rst_rdwe", rd_we, 0);
                chk("rst_addr", dmem_addr, 0);
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            exp_stall = hit && (cyc < total - 1);
            exp_act   = hit && (cyc >= 1) && (cyc <= 2 * n);
            exp_we    = exp_act && (cyc % 2 == 0);
            k         = exp_we ? (cyc - 2) / 2 : (cyc - 1) / 2;
            exp_addr  = exp_we ? dst + 32'(4 * k) : src + 32'(4 * k);
            chk("stall", stall, exp_stall);
            chk("mc_active", mc_active, exp_act);
            chk("dmem_we", dmem_we, exp_we);
            chk("rd_we", rd_we, hit && (cyc == total - 1) && (rd != 5'd0));
            if (exp_act) chk("dmem_addr", dmem_addr, exp_addr);
            if (exp_act && !exp_we) held = refm[exp_addr[9:2]];
            if (exp_we) begin
                chk("dmem_wdata", dmem_wdata, held);
                refm[exp_addr[9:2]] = held;
            end
            if (!hit) begin
                chk("idle_addr", dmem_addr, 0);
                chk("idle_wdata", dmem_wdata, 0);
                chk("idle_rdaddr", {27'd0, rd_addr}, 0);
                chk("idle_rdwdata", rd_wdata, 0);
            end
            if (hit && cyc == total - 1) begin
                chk("rd_addr", {27'd0, rd_addr}, {27'd0, rd});
                chk("rd_wdata", rd_wdata, 32'(n));
            end
            pend = dmem_we;
            pa   = dmem_addr;
            pd   = dmem_wdata;
            if (!stall) finished = 1'b1;
            cyc++;
            if (cyc > 400) begin
                chk("timeout", 32'(cyc), 32'(total));
                finished = 1'b1;
            end
            @(posedge clk);
            if (pend) mem[pa[9:2]] = pd;
        end
        chk_mem("mem");
    endtask

    initial begin
        logic [31:0] a;
        int n, f3;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        #12;
        chk("reset_stall", stall, 0);
        chk("reset_active", mc_active, 0);
        chk("reset_we", dmem_we, 0);
        chk("reset_rdwe", rd_we, 0);
        chk("reset_addr", dmem_addr, 0);
        chk("reset_wdata", dmem_wdata, 0);
        chk("reset_rdwdata", rd_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic copy: words 1..3 are a known pattern, x5=4, x7=60, N=10 into x10.
        for (int i = 1; i <= 3; i++) mem[i] = 32'h45678123;
        run_mc(32'h1472850B, 32'd4, 32'd60, -1);
        for (int i = 15; i <= 17; i++) chk("basic_pattern", mem[i], 32'h45678123);

        // Zero count, then a funct3 miss, then rd=x0, all back to back.
        run_mc(mk(0, 2, 1, 0, 3), 32'd100, 32'd200, -1);
        run_mc(mk(5, 2, 1, 1, 4), 32'd100, 32'd200, -1);
        run_mc(mk(4, 2, 1, 0, 0), 32'd40, 32'd400, -1);

        // Address wrap on source, misaligned destination base.
        run_mc(mk(2, 2, 1, 0, 6), 32'hFFFFFFFC, 32'h00000003, -1);

        // Overlapping ascending copy smears the first word.
        a = 32'hAAAA0001;
        mem[0] = a; mem[1] = 32'hBBBB0002; mem[2] = 32'hCCCC0003; mem[3] = 32'hDDDD0004;
        run_mc(mk(3, 2, 1, 0, 7), 32'd0, 32'd4, -1);
        for (int i = 1; i <= 3; i++) chk("overlap", mem[i], a);

        // Reset during the write of word 3 of a 10-word copy.
        run_mc(mk(10, 2, 1, 0, 9), 32'd512, 32'd768, 8);
        run_mc(mk(1, 2, 1, 0, 11), 32'd8, 32'd16, -1);

        for (int t = 0; t < 30; t++) begin
            n  = $urandom_range(0, 12);
            f3 = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            run_mc(mk(n, $urandom_range(0, 31), $urandom_range(0, 31), f3,
                      $urandom_range(0, 31)), $urandom, $urandom, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
